// File: rtl/ddr_arbiter_nch.sv
// N-channel arbiter multiplexing memory requests onto one DDR command port.
// Define DDR_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest eligible channel wins.
module ddr_arbiter_nch #(
  parameter int NUM_CH  = 3,
  parameter int INDEX_W = 19,
  parameter int DATA_W  = 64,
  parameter int BURST_W = 512
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         req_valid,
  output logic [NUM_CH-1:0]         req_ready,
  input  logic [NUM_CH*INDEX_W-1:0] req_index,
  input  logic [NUM_CH-1:0]         req_write,
  input  logic [NUM_CH-1:0]         req_burst,
  input  logic [NUM_CH*DATA_W-1:0]  req_wmask,
  input  logic [NUM_CH*DATA_W-1:0]  req_wdata,
  input  logic [NUM_CH-1:0]         flush_mask,
  output logic [NUM_CH-1:0]         resp_done,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic [BURST_W-1:0]        resp_burst,
  output logic                      ddr_chip_enable,
  output logic [INDEX_W-1:0]        ddr_index,
  output logic                      ddr_write_enable,
  output logic                      ddr_burst_mode,
  output logic [DATA_W-1:0]         ddr_write_mask,
  output logic [DATA_W-1:0]         ddr_write_data,
  input  logic [DATA_W-1:0]         ddr_read_data,
  input  logic [BURST_W-1:0]        ddr_burst_data,
  input  logic                      ddr_operation_done,
  input  logic                      ddr_ready
);
  localparam int CH_W = $clog2(NUM_CH);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;
  state_t r_state, w_state_nxt;

  logic [NUM_CH-1:0]  w_elig;
  logic               w_found;
  logic [CH_W-1:0]    w_sel;
  logic               w_grant;
  logic               w_done_ok;
  logic               w_flush_own;

  logic [CH_W-1:0]    r_owner;
  logic               r_drop;
  logic [NUM_CH-1:0]  r_req_ready;
  logic [NUM_CH-1:0]  r_resp_done;
  logic [DATA_W-1:0]  r_resp_rdata;
  logic [BURST_W-1:0] r_resp_burst;
  logic               r_ce;
  logic [INDEX_W-1:0] r_index;
  logic               r_we;
  logic               r_bm;
  logic [DATA_W-1:0]  r_wmask;
  logic [DATA_W-1:0]  r_wdata;

  assign w_elig      = req_valid & ~flush_mask;
  assign w_flush_own = flush_mask[r_owner];

`ifdef DDR_ARB_ROUND_ROBIN_EN
  localparam int SW = CH_W + 1;
  logic [CH_W-1:0] r_ptr;

  // Search starts at the pointer and wraps past NUM_CH-1 back to channel 0.
  always_comb begin : sel_rr
    logic [SW-1:0] w_pos;
    w_found = 1'b0;
    w_sel   = '0;
    w_pos   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_pos = {1'b0, r_ptr} + SW'(k);
      if (w_pos >= SW'(NUM_CH)) w_pos = w_pos - SW'(NUM_CH);
      if (!w_found && w_elig[w_pos[CH_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_pos[CH_W-1:0];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_ptr <= '0;
    else if (w_grant)
      r_ptr <= (w_sel == CH_W'(NUM_CH - 1)) ? '0 : w_sel + 1'b1;
  end
`else
  always_comb begin : sel_fixed
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!w_found && w_elig[i]) begin
        w_found = 1'b1;
        w_sel   = CH_W'(i);
      end
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Completions outside WAIT are stray and never reach the channels.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done_ok   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ddr_ready && w_found) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (ddr_operation_done) begin
          w_done_ok   = ~(r_drop | w_flush_own);
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_owner      <= '0;
      r_drop       <= 1'b0;
      r_req_ready  <= '0;
      r_resp_done  <= '0;
      r_resp_rdata <= '0;
      r_resp_burst <= '0;
      r_ce         <= 1'b0;
      r_index      <= '0;
      r_we         <= 1'b0;
      r_bm         <= 1'b0;
      r_wmask      <= '0;
      r_wdata      <= '0;
    end else begin
      r_req_ready <= '0;
      r_resp_done <= '0;
      r_ce        <= (r_state == ST_ISSUE);
      if (w_grant) begin
        r_req_ready[w_sel] <= 1'b1;
        r_owner <= w_sel;
        r_index <= INDEX_W'(req_index >> (w_sel * INDEX_W));
        r_we    <= req_write[w_sel];
        r_bm    <= req_burst[w_sel];
        r_wmask <= DATA_W'(req_wmask >> (w_sel * DATA_W));
        r_wdata <= DATA_W'(req_wdata >> (w_sel * DATA_W));
      end
      // A flush of the owner only suppresses the response; WAIT still runs to completion.
      if (r_state == ST_WAIT && ddr_operation_done)
        r_drop <= 1'b0;
      else if (r_state == ST_ISSUE || r_state == ST_WAIT)
        r_drop <= r_drop | w_flush_own;
      if (w_done_ok) begin
        r_resp_done[r_owner] <= 1'b1;
        r_resp_rdata <= ddr_read_data;
        r_resp_burst <= ddr_burst_data;
      end
    end
  end

  assign req_ready        = r_req_ready;
  assign resp_done        = r_resp_done;
  assign resp_rdata       = r_resp_rdata;
  assign resp_burst       = r_resp_burst;
  assign ddr_chip_enable  = r_ce;
  assign ddr_index        = r_index;
  assign ddr_write_enable = r_we;
  assign ddr_burst_mode   = r_bm;
  assign ddr_write_mask   = r_wmask;
  assign ddr_write_data   = r_wdata;

endmodule

// File: tb/tb_ddr_arbiter_nch.sv
// Self-checking bench for ddr_arbiter_nch: directed cases plus randomized traffic vs a reference model.
module tb_ddr_arbiter_nch;
  localparam int N  = 3;
  localparam int IW = 19;
  localparam int DW = 64;
  localparam int BW = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0, req_write = '0, req_burst = '0, flush_mask = '0;
  logic [N*IW-1:0] req_index = '0;
  logic [N*DW-1:0] req_wmask = '0, req_wdata = '0;
  logic [DW-1:0]   ddr_read_data = '0;
  logic [BW-1:0]   ddr_burst_data = '0;
  logic            ddr_operation_done = 1'b0, ddr_ready = 1'b1;

  logic [N-1:0]  req_ready, resp_done;
  logic [DW-1:0] resp_rdata, ddr_write_mask, ddr_write_data;
  logic [BW-1:0] resp_burst;
  logic          ddr_chip_enable, ddr_write_enable, ddr_burst_mode;
  logic [IW-1:0] ddr_index;

  ddr_arbiter_nch #(.NUM_CH(N), .INDEX_W(IW), .DATA_W(DW), .BURST_W(BW)) dut (
    .clock(clk), .reset(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
    .req_write(req_write), .req_burst(req_burst), .req_wmask(req_wmask),
    .req_wdata(req_wdata), .flush_mask(flush_mask), .resp_done(resp_done),
    .resp_rdata(resp_rdata), .resp_burst(resp_burst),
    .ddr_chip_enable(ddr_chip_enable), .ddr_index(ddr_index),
    .ddr_write_enable(ddr_write_enable), .ddr_burst_mode(ddr_burst_mode),
    .ddr_write_mask(ddr_write_mask), .ddr_write_data(ddr_write_data),
    .ddr_read_data(ddr_read_data), .ddr_burst_data(ddr_burst_data),
    .ddr_operation_done(ddr_operation_done), .ddr_ready(ddr_ready)
  );

  // Five-channel instance for the width/wrap checks.
  logic [4:0]    v5_valid = '0;
  logic          v5_done = 1'b0;
  logic [4:0]    o5_ready, o5_done;
  logic [DW-1:0] o5_rdata, o5_wmask, o5_wdata;
  logic [BW-1:0] o5_burst;
  logic          o5_ce, o5_we, o5_bm;
  logic [IW-1:0] o5_index;

  ddr_arbiter_nch #(.NUM_CH(5), .INDEX_W(IW), .DATA_W(DW), .BURST_W(BW)) dut5 (
    .clock(clk), .reset(rst),
    .req_valid(v5_valid), .req_ready(o5_ready), .req_index({5*IW{1'b0}}),
    .req_write(5'b0), .req_burst(5'b0), .req_wmask({5*DW{1'b0}}),
    .req_wdata({5*DW{1'b0}}), .flush_mask(5'b0), .resp_done(o5_done),
    .resp_rdata(o5_rdata), .resp_burst(o5_burst),
    .ddr_chip_enable(o5_ce), .ddr_index(o5_index),
    .ddr_write_enable(o5_we), .ddr_burst_mode(o5_bm),
    .ddr_write_mask(o5_wmask), .ddr_write_data(o5_wdata),
    .ddr_read_data({DW{1'b0}}), .ddr_burst_data({BW{1'b0}}),
    .ddr_operation_done(v5_done), .ddr_ready(1'b1)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  int            exp_ptr = 0;
  logic [DW-1:0] exp_rdata = '0;
  logic [BW-1:0] exp_burst = '0;

  task automatic chk(input string tag, input bit ok);
    tests++;
    if (!ok) begin
      fails++;
      $error("FAIL %s", tag);
    end
  endtask

  function automatic logic [N-1:0] oh(input int g);
    return (g < 0) ? '0 : (N'(1) << g);
  endfunction

  // Winner among eligible channels: rotated scan from the pointer, or lowest index.
  function automatic int arb(input logic [N-1:0] elig, input int ptr);
    int order;
    for (int k = 0; k < N; k++) begin
`ifdef DDR_ARB_ROUND_ROBIN_EN
      order = (ptr + k) % N;
`else
      order = k;
`endif
      if (((elig >> order) & N'(1)) != '0) return order;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".req_ready"}, req_ready === '0);
    chk({tag, ".resp_done"}, resp_done === '0);
    chk({tag, ".resp_rdata"}, resp_rdata === '0);
    chk({tag, ".resp_burst"}, resp_burst === '0);
    chk({tag, ".ce"}, ddr_chip_enable === 1'b0);
    chk({tag, ".index"}, ddr_index === '0);
    chk({tag, ".we"}, ddr_write_enable === 1'b0);
    chk({tag, ".bm"}, ddr_burst_mode === 1'b0);
    chk({tag, ".wmask"}, ddr_write_mask === '0);
    chk({tag, ".wdata"}, ddr_write_data === '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; flush_mask = '0; ddr_operation_done = 1'b0; ddr_ready = 1'b1;
    tick();
    check_zero("reset");
    chk("reset.r5", o5_ready === 5'b0);
    tick();
    rst = 1'b0;
    exp_ptr = 0; exp_rdata = '0; exp_burst = '0;
  endtask

  task automatic rand_fields();
    for (int c = 0; c < N; c++) begin
      req_index[c*IW +: IW] = IW'($urandom);
      req_wmask[c*DW +: DW] = {$urandom, $urandom};
      req_wdata[c*DW +: DW] = {$urandom, $urandom};
    end
    req_write = N'($urandom_range(0, 7));
    req_burst = N'($urandom_range(0, 7));
  endtask

  function automatic logic [BW-1:0] rand_burst();
    logic [BW-1:0] b;
    for (int w = 0; w < BW / 32; w++) b[w*32 +: 32] = $urandom;
    return b;
  endfunction

  // Requests must already be driven in an IDLE cycle. fmode: 0 none, 1 flush in WAIT, 2 flush at completion.
  task automatic run_txn(input int lat, input int fmode, input logic [DW-1:0] rd,
                         input logic [BW-1:0] bd, output logic [N-1:0] seen);
    int g;
    logic [IW-1:0] ei;
    logic ew, eb, drop;
    logic [DW-1:0] em, ed;
    g = ddr_ready ? arb(req_valid & ~flush_mask, exp_ptr) : -1;
    tick();
    seen = req_ready;
    chk("req_ready", req_ready === oh(g));
    if (g < 0) return;
    ei = IW'(req_index >> (g * IW));
    em = DW'(req_wmask >> (g * DW));
    ed = DW'(req_wdata >> (g * DW));
    ew = (req_write & oh(g)) != '0;
    eb = (req_burst & oh(g)) != '0;
    req_valid = req_valid & ~oh(g);
`ifdef DDR_ARB_ROUND_ROBIN_EN
    exp_ptr = (g + 1) % N;
`endif
    tick();
    chk("ce", ddr_chip_enable === 1'b1);
    chk("ddr_index", ddr_index === ei);
    chk("ddr_we", ddr_write_enable === ew);
    chk("ddr_burst", ddr_burst_mode === eb);
    if (ew) begin
      chk("ddr_wmask", ddr_write_mask === em);
      chk("ddr_wdata", ddr_write_data === ed);
    end
    drop = (fmode != 0);
    for (int i = 1; i < lat; i++) begin
      if (fmode == 1 && i == 1) flush_mask = flush_mask | oh(g);
      tick();
      flush_mask = flush_mask & ~oh(g);
    end
    chk("ce_pulse", ddr_chip_enable === 1'b0);
    chk("done_early", resp_done === '0);
    ddr_operation_done = 1'b1; ddr_read_data = rd; ddr_burst_data = bd;
    if (fmode == 2) flush_mask = flush_mask | oh(g);
    tick();
    ddr_operation_done = 1'b0;
    flush_mask = flush_mask & ~oh(g);
    if (!drop) begin exp_rdata = rd; exp_burst = bd; end
    chk("resp_done", resp_done === (drop ? '0 : oh(g)));
    chk("resp_rdata", resp_rdata === exp_rdata);
    chk("resp_burst", resp_burst === exp_burst);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] seen;
    logic [11:0]  rr_exp;
    do_reset();

    // Single read on ch1, completion five cycles after acceptance
    rand_fields();
    req_index[1*IW +: IW] = 19'h12345;
    req_write = '0; req_burst = '0;
    req_valid = 3'b010;
    run_txn(5, 0, 64'hDEAD_BEEF, rand_burst(), seen);
    chk("single.grant", seen === 3'b010);
    chk("single.rdata", resp_rdata === 64'hDEAD_BEEF);

    // Flush of the owner during WAIT: response suppressed, burst data kept
    req_burst = 3'b001; req_write = '0;
    req_valid = 3'b001;
    run_txn(4, 1, {$urandom, $urandom}, rand_burst(), seen);
    chk("flushwait.grant", seen === 3'b001);

    // Request and flush in the same cycle: no grant until the flush drops
    rand_fields();
    req_valid = 3'b100; flush_mask = 3'b100;
    run_txn(3, 0, '0, '0, seen);
    tick();
    chk("reqflush.no_ce", ddr_chip_enable === 1'b0);
    chk("reqflush.no_ready", req_ready === '0);
    flush_mask = '0;
    run_txn(3, 0, {$urandom, $urandom}, rand_burst(), seen);
    chk("reqflush.grant", seen === 3'b100);

    // Arbitration order with every channel requesting, from reset
    do_reset();
`ifdef DDR_ARB_ROUND_ROBIN_EN
    rr_exp = {3'b001, 3'b100, 3'b010, 3'b001};
`else
    rr_exp = {3'b001, 3'b001, 3'b001, 3'b001};
`endif
    for (int k = 0; k < 4; k++) begin
      rand_fields();
      req_valid = 3'b111;
      run_txn(2, 0, {$urandom, $urandom}, rand_burst(), seen);
      chk("order", seen === 3'(rr_exp >> (3 * k)));
    end
    req_valid = '0;
    tick();

    // Write on ch1, then reset while waiting for DDR
    req_index[1*IW +: IW] = 19'h00ABC;
    req_wmask[1*DW +: DW] = 64'hFF;
    req_wdata[1*DW +: DW] = 64'h55;
    req_write = 3'b010; req_burst = '0;
    req_valid = 3'b010;
    tick();
    chk("wr.grant", req_ready === 3'b010);
    req_valid = '0;
    tick();
    chk("wr.ce", ddr_chip_enable === 1'b1);
    chk("wr.we", ddr_write_enable === 1'b1);
    chk("wr.mask", ddr_write_mask === 64'hFF);
    chk("wr.data", ddr_write_data === 64'h55);
    tick();
    rst = 1'b1;
    #1;
    check_zero("midreset");
    tick();
    rst = 1'b0;
    exp_ptr = 0; exp_rdata = '0; exp_burst = '0;
    ddr_operation_done = 1'b1; ddr_read_data = 64'h1234; ddr_burst_data = rand_burst();
    tick();
    ddr_operation_done = 1'b0;
    chk("stray.done", resp_done === '0);
    chk("stray.ce", ddr_chip_enable === 1'b0);
    chk("stray.rdata", resp_rdata === exp_rdata);
    tick();
    chk("stray.done2", resp_done === '0);

    // Five-channel build: lone ch4, then wrap to ch0
    v5_valid = 5'b10000;
    tick();
    chk("n5.grant4", o5_ready === 5'b10000);
    v5_valid = '0;
    tick();
    chk("n5.ce", o5_ce === 1'b1);
    tick();
    v5_done = 1'b1;
    tick();
    v5_done = 1'b0;
    chk("n5.done4", o5_done === 5'b10000);
    v5_valid = 5'b11111;
    tick();
    chk("n5.wrap", o5_ready === 5'b00001);
    v5_valid = '0;
    tick(); tick();
    v5_done = 1'b1;
    tick();
    v5_done = 1'b0;
    chk("n5.done0", o5_done === 5'b00001);

    // Randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      rand_fields();
      req_valid  = N'($urandom_range(0, 7));
      flush_mask = ($urandom_range(0, 3) == 0) ? N'($urandom_range(1, 7)) : '0;
      ddr_ready  = ($urandom_range(0, 4) != 0);
      run_txn(int'($urandom_range(2, 6)), int'($urandom_range(0, 2)),
              {$urandom, $urandom}, rand_burst(), seen);
      ddr_ready = 1'b1; flush_mask = '0; req_valid = '0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
